// File: rtl/host_mem_rd_arbiter_axi_if.sv
// Engine-side and memory-side AXI read channels (AR + R) of the host memory read arbiter.
// mem_arid/mem_rid carry the engine index above the engine's own ID bits.
interface host_mem_rd_arbiter_axi_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int RID_WIDTH  = 8
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_arvalid;
  logic [N_REQ-1:0]            req_arready;
  logic [N_REQ*ADDR_WIDTH-1:0] req_araddr;
  logic [N_REQ*RID_WIDTH-1:0]  req_arid;
  logic [N_REQ*8-1:0]          req_arlen;
  logic [N_REQ-1:0]            req_rvalid;
  logic [N_REQ-1:0]            req_rready;
  logic [DATA_WIDTH-1:0]       req_rdata;
  logic [RID_WIDTH-1:0]        req_rid;
  logic [1:0]                  req_rresp;
  logic                        req_rlast;

  logic                        mem_arvalid;
  logic                        mem_arready;
  logic [ADDR_WIDTH-1:0]       mem_araddr;
  logic [RID_WIDTH+IDX_W-1:0]  mem_arid;
  logic [7:0]                  mem_arlen;
  logic                        mem_rvalid;
  logic                        mem_rready;
  logic [DATA_WIDTH-1:0]       mem_rdata;
  logic [RID_WIDTH+IDX_W-1:0]  mem_rid;
  logic [1:0]                  mem_rresp;
  logic                        mem_rlast;

  // Arbiter view
  modport master (
    input  req_arvalid, req_araddr, req_arid, req_arlen, req_rready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rid, mem_rresp, mem_rlast,
    output req_arready, req_rvalid, req_rdata, req_rid, req_rresp, req_rlast,
    output mem_arvalid, mem_araddr, mem_arid, mem_arlen, mem_rready
  );

  // Engines + memory sink view
  modport slave (
    output req_arvalid, req_araddr, req_arid, req_arlen, req_rready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rid, mem_rresp, mem_rlast,
    input  req_arready, req_rvalid, req_rdata, req_rid, req_rresp, req_rlast,
    input  mem_arvalid, mem_araddr, mem_arid, mem_arlen, mem_rready
  );
endinterface

// File: rtl/host_mem_rd_arbiter_axi.sv
// Round-robin AR arbiter with per-engine outstanding-burst credits; R beats are
// steered back to engines combinationally using the index in the upper RID bits.
module host_mem_rd_arbiter_axi #(
  parameter int N_REQ           = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int RID_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  host_mem_rd_arbiter_axi_if.master bus,
  output logic                   bad_rid_err
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int N_IDX = 1 << IDX_W;

  logic [IDX_W-1:0]      rr, gnt_idx, rr_next;
  logic [N_REQ-1:0]      eligible, grant;
  logic                  gnt_valid, slot_open, take;
  logic [CNT_W-1:0]      cnt [N_REQ];

  logic                  ar_valid;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [RID_WIDTH+IDX_W-1:0] ar_id;
  logic [7:0]            ar_len;

  logic [IDX_W-1:0]      k;
  logic [N_IDX-1:0]      idx_ok;
  logic                  k_ok, sel_ready, r_ready, r_last_hs;
  logic [N_REQ-1:0]      r_valid;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++)
      eligible[i] = bus.req_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
  end

  // First eligible engine at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      int unsigned idx;
      idx = (32'(rr) + off) % unsigned'(N_REQ);
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

  assign slot_open = !ar_valid || bus.mem_arready;
  assign take      = slot_open && gnt_valid && reset_n;
  assign grant     = take ? (N_REQ'(1) << gnt_idx) : '0;
  assign rr_next   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_len   <= '0;
      rr       <= '0;
    end else if (slot_open) begin
      ar_valid <= gnt_valid;
      if (gnt_valid) begin
        ar_addr <= bus.req_araddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ar_id   <= {gnt_idx, bus.req_arid[gnt_idx*RID_WIDTH +: RID_WIDTH]};
        ar_len  <= bus.req_arlen[gnt_idx*8 +: 8];
        rr      <= rr_next;
      end
    end
  end

  assign k = bus.mem_rid[RID_WIDTH +: IDX_W];

  // Indices beyond N_REQ only exist when N_REQ is not a power of two.
  always_comb begin
    for (int unsigned i = 0; i < N_IDX; i++)
      idx_ok[i] = (i < unsigned'(N_REQ));
  end

  assign k_ok = idx_ok[k];

  always_comb begin
    r_valid   = '0;
    sel_ready = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (k == IDX_W'(i)) begin
        r_valid[i] = bus.mem_rvalid;
        sel_ready  = bus.req_rready[i];
      end
    end
  end

  assign r_ready   = k_ok ? sel_ready : 1'b1;
  assign r_last_hs = bus.mem_rvalid && r_ready && bus.mem_rlast && k_ok;

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic inc, dec;
    assign inc = grant[i];
    assign dec = r_last_hs && (k == IDX_W'(i));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        cnt[i] <= '0;
      else if (inc && !dec && cnt[i] != CNT_W'(MAX_OUTSTANDING))
        cnt[i] <= cnt[i] + 1'b1;
      else if (dec && !inc && cnt[i] != '0)
        cnt[i] <= cnt[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bad_rid_err <= 1'b0;
    else if (bus.mem_rvalid && !k_ok)
      bad_rid_err <= 1'b1;
  end

  assign bus.req_arready = grant;
  assign bus.mem_arvalid = ar_valid;
  assign bus.mem_araddr  = ar_addr;
  assign bus.mem_arid    = ar_id;
  assign bus.mem_arlen   = ar_len;
  assign bus.req_rvalid  = r_valid;
  assign bus.mem_rready  = r_ready;
  assign bus.req_rdata   = bus.mem_rdata;
  assign bus.req_rid     = bus.mem_rid[RID_WIDTH-1:0];
  assign bus.req_rresp   = bus.mem_rresp;
  assign bus.req_rlast   = bus.mem_rlast;
endmodule

// File: tb/tb_host_mem_rd_arbiter_axi.sv
// Scoreboard bench for host_mem_rd_arbiter_axi: a 4-engine instance for arbitration,
// credits, R steering and reset, and a 3-engine instance for out-of-range RID handling.
module tb_host_mem_rd_arbiter_axi;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 8;

  typedef struct {
    logic [9:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [3:0]  rvalid;
    logic        rready;
    logic [7:0]  rid;
    logic [31:0] data;
    logic        last;
  } rexp_t;

  logic clk;
  logic reset_n;
  logic bad_rid_err, bad3;

  int n_cmp = 0;
  int n_bad = 0;

  ar_t         ar_q [$];
  rexp_t       r_q  [$];
  logic [31:0] addr [4];

  host_mem_rd_arbiter_axi_if #(.N_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RID_WIDTH(RW)) bus ();
  host_mem_rd_arbiter_axi_if #(.N_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RID_WIDTH(RW)) bus3 ();

  host_mem_rd_arbiter_axi #(
    .N_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RID_WIDTH(RW), .MAX_OUTSTANDING(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master), .bad_rid_err(bad_rid_err)
  );

  host_mem_rd_arbiter_axi #(
    .N_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RID_WIDTH(RW), .MAX_OUTSTANDING(32)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.master), .bad_rid_err(bad3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int e, input logic [31:0] a);
    addr[e] = a;
    bus.req_araddr[e*32 +: 32] = a;
  endtask

  task automatic push_ar(input int e);
    ar_t t;
    t.id   = 10'(e * 256 + 16 + e);
    t.addr = addr[e];
    t.len  = 8'(4 * e + 1);
    ar_q.push_back(t);
  endtask

  task automatic r_drive(input int k, input logic [7:0] id, input logic [31:0] d,
                         input logic last, input logic [3:0] rdy,
                         input logic [3:0] ev, input logic er);
    rexp_t t;
    bus.mem_rvalid = 1'b1;
    bus.mem_rid    = {2'(k), id};
    bus.mem_rdata  = d;
    bus.mem_rlast  = last;
    bus.mem_rresp  = 2'b00;
    bus.req_rready = rdy;
    t.rvalid = ev;
    t.rready = er;
    t.rid    = id;
    t.data   = d;
    t.last   = last;
    r_q.push_back(t);
  endtask

  task automatic r_idle();
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    bus.req_rready = '0;
  endtask

  // AR monitor: every accepted AR must match the next expected grant.
  always @(negedge clk) begin : mon_ar
    ar_t e;
    if (reset_n && bus.mem_arvalid && bus.mem_arready) begin
      if (ar_q.size() == 0) begin
        chk("ar_unexpected", 64'd1, 64'd0);
      end else begin
        e = ar_q.pop_front();
        chk("ar_id", 64'(bus.mem_arid), 64'(e.id));
        chk("ar_addr", 64'(bus.mem_araddr), 64'(e.addr));
        chk("ar_len", 64'(bus.mem_arlen), 64'(e.len));
      end
    end
  end

  // R monitor: every presented R beat must be steered as expected.
  always @(negedge clk) begin : mon_r
    rexp_t e;
    if (reset_n && bus.mem_rvalid) begin
      if (r_q.size() == 0) begin
        chk("r_unexpected", 64'd1, 64'd0);
      end else begin
        e = r_q.pop_front();
        chk("r_valid_vec", 64'(bus.req_rvalid), 64'(e.rvalid));
        chk("r_mem_ready", 64'(bus.mem_rready), 64'(e.rready));
        chk("r_rid", 64'(bus.req_rid), 64'(e.rid));
        chk("r_data", 64'(bus.req_rdata), 64'(e.data));
        chk("r_last", 64'(bus.req_rlast), 64'(e.last));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.req_arvalid = '0;
    bus.req_araddr  = '0;
    bus.req_arid    = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_arlen   = {8'd13, 8'd9, 8'd5, 8'd1};
    bus.req_rready  = '0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rid     = '0;
    bus.mem_rresp   = '0;
    bus.mem_rlast   = 1'b0;
    bus3.req_arvalid = '0;
    bus3.req_araddr  = '0;
    bus3.req_arid    = '0;
    bus3.req_arlen   = '0;
    bus3.req_rready  = '0;
    bus3.mem_arready = 1'b0;
    bus3.mem_rvalid  = 1'b0;
    bus3.mem_rdata   = '0;
    bus3.mem_rid     = '0;
    bus3.mem_rresp   = '0;
    bus3.mem_rlast   = 1'b0;
    for (int e = 0; e < 4; e++) set_addr(e, 32'(32'hA000_0000 + e * 256));

    // Reset state, with requests present
    step();
    step();
    bus.req_arvalid = 4'hF;
    #1;
    chk("rst_arready", 64'(bus.req_arready), 64'd0);
    chk("rst_arvalid", 64'(bus.mem_arvalid), 64'd0);
    chk("rst_bad_rid", 64'(bad_rid_err), 64'd0);
    chk("rst_bad_rid3", 64'(bad3), 64'd0);
    bus.req_arvalid = '0;
    step();
    reset_n = 1'b1;
    step();

    // Round robin at one grant per cycle
    bus.mem_arready = 1'b1;
    bus.req_arvalid = 4'hF;
    for (int n = 0; n < 8; n++) begin
      #1 chk("rr_grant", 64'(bus.req_arready), 64'(1 << (n % 4)));
      push_ar(n % 4);
      step();
    end
    bus.req_arvalid = '0;
    step();
    step();

    // Sink back-pressure on engine 2
    bus.mem_arready = 1'b0;
    bus.req_arvalid = 4'b0100;
    #1 chk("stall_first_grant", 64'(bus.req_arready), 64'h4);
    push_ar(2);
    step();
    set_addr(2, 32'hB000_0002);
    for (int n = 0; n < 5; n++) begin
      #1 chk("stall_no_grant", 64'(bus.req_arready), 64'd0);
      chk("stall_valid", 64'(bus.mem_arvalid), 64'd1);
      chk("stall_addr", 64'(bus.mem_araddr), 64'hA000_0200);
      chk("stall_id", 64'(bus.mem_arid), 64'h212);
      step();
    end
    bus.mem_arready = 1'b1;
    #1 chk("resume_grant", 64'(bus.req_arready), 64'h4);
    push_ar(2);
    step();
    bus.req_arvalid = '0;
    #1 chk("next_ar_valid", 64'(bus.mem_arvalid), 64'd1);
    step();
    #1 chk("idle_ar_valid", 64'(bus.mem_arvalid), 64'd0);

    // Credit limit on engine 1 (2 bursts already in flight)
    bus.req_arvalid = 4'b0010;
    for (int n = 0; n < 30; n++) begin
      #1 chk("credit_fill", 64'(bus.req_arready), 64'h2);
      push_ar(1);
      step();
    end
    #1 chk("credit_block", 64'(bus.req_arready), 64'd0);
    bus.req_arvalid = 4'hF;
    for (int j = 2; j < 5; j++) begin
      #1 chk("credit_others", 64'(bus.req_arready), 64'(1 << (j % 4)));
      push_ar(j % 4);
      step();
    end
    bus.req_arvalid = 4'b0010;
    #1 chk("credit_still_block", 64'(bus.req_arready), 64'd0);
    step();
    r_drive(1, 8'h11, 32'h1111_0001, 1'b1, 4'b0010, 4'b0010, 1'b1);
    #1 chk("credit_same_cycle", 64'(bus.req_arready), 64'd0);
    step();
    r_idle();
    #1 chk("credit_return", 64'(bus.req_arready), 64'h2);
    push_ar(1);
    step();
    bus.req_arvalid = '0;
    step();
    step();

    // R steering and back-pressure
    r_drive(3, 8'h5A, 32'hDEAD_0003, 1'b0, 4'b0000, 4'b1000, 1'b0);
    step();
    r_drive(3, 8'h5A, 32'hDEAD_0003, 1'b0, 4'b0111, 4'b1000, 1'b0);
    step();
    r_drive(3, 8'h5A, 32'hBEEF_0003, 1'b1, 4'b1000, 4'b1000, 1'b1);
    step();
    r_drive(0, 8'h10, 32'h0000_0A0A, 1'b0, 4'b1110, 4'b0001, 1'b0);
    step();
    r_drive(2, 8'h12, 32'h1234_5678, 1'b1, 4'b1111, 4'b0100, 1'b1);
    step();
    r_drive(0, 8'h10, 32'h0000_0B0B, 1'b1, 4'b0001, 4'b0001, 1'b1);
    step();
    r_idle();
    #1 chk("pow2_no_bad_rid", 64'(bad_rid_err), 64'd0);

    // Out-of-range index on the 3-engine instance
    bus3.mem_rvalid = 1'b1;
    bus3.mem_rid    = {2'd2, 8'h22};
    bus3.req_rready = 3'b100;
    #1 chk("n3_valid_vec", 64'(bus3.req_rvalid), 64'h4);
    chk("n3_valid_ready", 64'(bus3.mem_rready), 64'd1);
    step();
    chk("n3_no_err_yet", 64'(bad3), 64'd0);
    bus3.mem_rid    = {2'd3, 8'h77};
    bus3.req_rready = 3'b000;
    #1 chk("n3_bad_ready", 64'(bus3.mem_rready), 64'd1);
    chk("n3_bad_no_valid", 64'(bus3.req_rvalid), 64'd0);
    chk("n3_err_registered", 64'(bad3), 64'd0);
    step();
    bus3.mem_rvalid = 1'b0;
    #1 chk("n3_err_set", 64'(bad3), 64'd1);
    step();
    step();
    chk("n3_err_sticky", 64'(bad3), 64'd1);

    // Asynchronous reset while an AR is stalled
    bus.mem_arready = 1'b0;
    bus.req_arvalid = 4'b0001;
    #1 chk("pre_rst_grant", 64'(bus.req_arready), 64'h1);
    step();
    #1 chk("pre_rst_valid", 64'(bus.mem_arvalid), 64'd1);
    reset_n = 1'b0;
    #1 chk("async_rst_valid", 64'(bus.mem_arvalid), 64'd0);
    chk("async_rst_arready", 64'(bus.req_arready), 64'd0);
    chk("async_rst_err3", 64'(bad3), 64'd0);
    step();
    reset_n = 1'b1;
    bus.mem_arready = 1'b1;
    bus.req_arvalid = 4'hF;
    #1 chk("post_rst_grant0", 64'(bus.req_arready), 64'h1);
    push_ar(0);
    step();
    #1 chk("post_rst_grant1", 64'(bus.req_arready), 64'h2);
    push_ar(1);
    step();
    bus.req_arvalid = '0;
    step();
    step();

    chk("ar_queue_empty", 64'(ar_q.size()), 64'd0);
    chk("r_queue_empty", 64'(r_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
